// File: rtl/regfile_pkg.sv
// Shared constants and helpers for the multi-port register file.
package regfile_pkg;

   localparam int DW     = 32;
   localparam int NREG   = 16;
   localparam int AW     = $clog2(NREG);
   localparam int PC_IDX = NREG - 1;

   // Widest pending vector popcount accepts; narrower vectors are zero-extended.
   localparam int POP_W  = 64;

   function automatic int popcount(input logic [POP_W-1:0] v);
      int n;
      n = 0;
      for (int i = 0; i < POP_W; i++) begin
         if (v[i]) n++;
      end
      return n;
   endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-load scoreboard: one bit per architectural register (PC excluded),
// a registered population count, and busy lookups for three read addresses.
module regfile_scoreboard #(
   parameter  int NREG = regfile_pkg::NREG,
   localparam int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   input  logic [AW-1:0] ra3,
   input  logic          web,
   input  logic [AW-1:0] wab,
   input  logic          iss_en,
   input  logic [AW-1:0] iss_addr,
   output logic          busy1,
   output logic          busy2,
   output logic          busy3,
   output logic          pend_any,
   output logic [AW:0]   pend_cnt
);
   import regfile_pkg::*;

   logic [NREG-2:0] pend_q;
   logic [NREG-2:0] pend_nxt;
   logic [AW:0]     cnt_q;

   // A register is busy while its load is outstanding, except in the cycle the
   // load data arrives on port B (the bypass already supplies it). PC never busy.
   function automatic logic lookup(input logic [AW-1:0]   ra,
                                   input logic [NREG-2:0] pend,
                                   input logic            we,
                                   input logic [AW-1:0]   wa);
      logic b;
      b = 1'b0;
      for (int i = 0; i < NREG - 1; i++) begin
         if (ra == AW'(i)) b = pend[i];
      end
      return b && !(we && (wa == ra));
   endfunction

   // Next pending state: a new issue supersedes a same-cycle load return.
   always_comb begin
      pend_nxt = pend_q;
      for (int i = 0; i < NREG - 1; i++) begin
         if (iss_en && (iss_addr == AW'(i))) begin
            pend_nxt[i] = 1'b1;
         end else if (web && (wab == AW'(i))) begin
            pend_nxt[i] = 1'b0;
         end
      end
   end

   // Pending bits and their count are registered together so they never disagree.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pend_q <= '0;
         cnt_q  <= '0;
      end else begin
         pend_q <= pend_nxt;
         cnt_q  <= (AW+1)'(popcount(POP_W'(pend_nxt)));
      end
   end

   assign busy1    = lookup(ra1, pend_q, web, wab);
   assign busy2    = lookup(ra2, pend_q, web, wab);
   assign busy3    = lookup(ra3, pend_q, web, wab);
   assign pend_cnt = cnt_q;
   assign pend_any = (cnt_q != '0);

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two write ports (B beats A on a shared address),
// three combinational write-first read ports, externally supplied PC, and a
// pending-load scoreboard for RAW stalls.
module regfile_mp #(
   parameter  int DW   = regfile_pkg::DW,
   parameter  int NREG = regfile_pkg::NREG,
   localparam int AW   = $clog2(NREG)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [AW-1:0] ra1,
   input  logic [AW-1:0] ra2,
   input  logic [AW-1:0] ra3,
   output logic [DW-1:0] rd1,
   output logic [DW-1:0] rd2,
   output logic [DW-1:0] rd3,
   output logic          busy1,
   output logic          busy2,
   output logic          busy3,
   input  logic          wea,
   input  logic [AW-1:0] waa,
   input  logic [DW-1:0] wda,
   input  logic          web,
   input  logic [AW-1:0] wab,
   input  logic [DW-1:0] wdb,
   input  logic          iss_en,
   input  logic [AW-1:0] iss_addr,
   input  logic [DW-1:0] pc,
   output logic          pend_any,
   output logic [AW:0]   pend_cnt
);
   import regfile_pkg::*;

   localparam int PIDX = NREG - 1;

   logic [DW-1:0] regs [NREG-1];
   logic [AW-1:0] ra_a [3];
   logic [DW-1:0] rd_a [3];

   // Storage: only indices 0..NREG-2 exist, so PC-addressed writes fall away.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NREG - 1; i++) regs[i] <= '0;
      end else begin
         for (int i = 0; i < NREG - 1; i++) begin
            if (web && (wab == AW'(i))) begin
               regs[i] <= wdb;
            end else if (wea && (waa == AW'(i))) begin
               regs[i] <= wda;
            end
         end
      end
   end

   assign ra_a[0] = ra1;
   assign ra_a[1] = ra2;
   assign ra_a[2] = ra3;

   // Read muxes: PC, then port B bypass, then port A bypass, then storage.
   always_comb begin
      for (int k = 0; k < 3; k++) begin
         rd_a[k] = '0;
         if (ra_a[k] == AW'(PIDX)) begin
            rd_a[k] = pc;
         end else if (reset) begin
            rd_a[k] = '0;
         end else if (web && (wab == ra_a[k])) begin
            rd_a[k] = wdb;
         end else if (wea && (waa == ra_a[k])) begin
            rd_a[k] = wda;
         end else begin
            for (int i = 0; i < NREG - 1; i++) begin
               if (ra_a[k] == AW'(i)) rd_a[k] = regs[i];
            end
         end
      end
   end

   assign rd1 = rd_a[0];
   assign rd2 = rd_a[1];
   assign rd3 = rd_a[2];

   regfile_scoreboard #(
      .NREG (NREG)
   ) u_sb (
      .clk      (clk),
      .reset    (reset),
      .ra1      (ra1),
      .ra2      (ra2),
      .ra3      (ra3),
      .web      (web),
      .wab      (wab),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .busy1    (busy1),
      .busy2    (busy2),
      .busy3    (busy3),
      .pend_any (pend_any),
      .pend_cnt (pend_cnt)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios plus a randomized run against an
// array-based reference model.
module tb_regfile_mp;

   localparam int DW   = 32;
   localparam int NREG = 16;
   localparam int AW   = 4;
   localparam int PC   = NREG - 1;

   logic          clk = 1'b0;
   logic          reset;
   logic [AW-1:0] ra1, ra2, ra3;
   logic [DW-1:0] rd1, rd2, rd3;
   logic          busy1, busy2, busy3;
   logic          wea, web, iss_en;
   logic [AW-1:0] waa, wab, iss_addr;
   logic [DW-1:0] wda, wdb, pc;
   logic          pend_any;
   logic [AW:0]   pend_cnt;

   int vectors    = 0;
   int miscompares = 0;

   logic [DW-1:0]   mregs [0:NREG-2];
   logic [NREG-2:0] mpend;

   regfile_mp dut (
      .clk      (clk),
      .reset    (reset),
      .ra1      (ra1),
      .ra2      (ra2),
      .ra3      (ra3),
      .rd1      (rd1),
      .rd2      (rd2),
      .rd3      (rd3),
      .busy1    (busy1),
      .busy2    (busy2),
      .busy3    (busy3),
      .wea      (wea),
      .waa      (waa),
      .wda      (wda),
      .web      (web),
      .wab      (wab),
      .wdb      (wdb),
      .iss_en   (iss_en),
      .iss_addr (iss_addr),
      .pc       (pc),
      .pend_any (pend_any),
      .pend_cnt (pend_cnt)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, vectors=%0d", vectors);
      $fatal(1);
   end

   // Reference read: PC, then the newest write this cycle, then architectural state.
   function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] ra);
      if (ra == AW'(PC)) return pc;
      if (reset) return '0;
      if (web && wab == ra) return wdb;
      if (wea && waa == ra) return wda;
      return mregs[ra];
   endfunction

   function automatic logic exp_busy(input logic [AW-1:0] ra);
      if (ra == AW'(PC) || reset) return 1'b0;
      return mpend[ra] && !(web && wab == ra);
   endfunction

   task automatic idle();
      wea = 1'b0; web = 1'b0; iss_en = 1'b0;
   endtask

   // Advance one clock and apply the architectural effect of the current inputs.
   task automatic tick();
      if (!reset) begin
         if (wea && waa != AW'(PC)) mregs[waa] = wda;
         if (web && wab != AW'(PC)) begin
            mregs[wab] = wdb;
            mpend[wab] = 1'b0;
         end
         if (iss_en && iss_addr != AW'(PC)) mpend[iss_addr] = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      idle();
      waa = '0; wab = '0; iss_addr = '0; wda = '0; wdb = '0;
      ra1 = 4'd1; ra2 = 4'd2; ra3 = 4'd3;
      pc = 32'h0000_1008;
      for (int i = 0; i < NREG - 1; i++) mregs[i] = '0;
      mpend = '0;
      repeat (3) @(posedge clk);
      #1;
      vectors++;
      if (pend_cnt !== '0 || pend_any !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_cnt: pend_cnt=%0d pend_any=%b, required 0/0", pend_cnt, pend_any);
      end
      reset = 1'b0;
      #1;
      for (int a = 0; a < NREG; a++) begin
         ra1 = AW'(a);
         #1;
         vectors++;
         if (a == PC) begin
            if (rd1 !== 32'h0000_1008) begin
               miscompares++;
               $display("FAIL reset_pc: rd1=%h, required 00001008", rd1);
            end
         end else if (rd1 !== '0 || busy1 !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_read R%0d: rd1=%h busy1=%b, required 0/0", a, rd1, busy1);
         end
      end
   endtask

   task automatic test_bypass();
      wea = 1'b1; waa = 4'd3; wda = 32'hDEAD_BEEF; ra1 = 4'd3;
      #1;
      vectors++;
      if (rd1 !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL bypass_a: rd1=%h, required deadbeef", rd1);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (rd1 !== 32'hDEAD_BEEF) begin
         miscompares++;
         $display("FAIL stored_a: rd1=%h, required deadbeef", rd1);
      end
   endtask

   task automatic test_dual_write();
      wea = 1'b1; waa = 4'd5; wda = 32'h11;
      web = 1'b1; wab = 4'd5; wdb = 32'h22;
      ra2 = 4'd5;
      #1;
      vectors++;
      if (rd2 !== 32'h22) begin
         miscompares++;
         $display("FAIL same_addr_bypass: rd2=%h, required 22", rd2);
      end
      tick();
      idle();
      wea = 1'b1; waa = 4'd15; wda = 32'h55; ra1 = 4'd15;
      #1;
      vectors++;
      if (rd1 !== 32'h0000_1008 || rd2 !== 32'h22) begin
         miscompares++;
         $display("FAIL pc_write_bypass: rd1=%h rd2=%h, required 00001008/22", rd1, rd2);
      end
      tick();
      idle();
      #1;
      for (int i = 0; i < NREG; i++) begin
         ra3 = AW'(i);
         #1;
         vectors++;
         if (rd3 !== exp_rd(ra3) || rd3 === 32'h55) begin
            miscompares++;
            $display("FAIL pc_write_storage R%0d: rd3=%h, required %h", i, rd3, exp_rd(ra3));
         end
      end
   endtask

   task automatic test_scoreboard();
      iss_en = 1'b1; iss_addr = 4'd7;
      tick();
      idle();
      ra2 = 4'd7;
      #1;
      vectors++;
      if (busy2 !== 1'b1 || pend_cnt !== 5'd1 || pend_any !== 1'b1) begin
         miscompares++;
         $display("FAIL load_pending: busy2=%b pend_cnt=%0d pend_any=%b, required 1/1/1", busy2, pend_cnt, pend_any);
      end
      web = 1'b1; wab = 4'd7; wdb = 32'h1234;
      #1;
      vectors++;
      if (busy2 !== 1'b0 || rd2 !== 32'h1234 || pend_cnt !== 5'd1) begin
         miscompares++;
         $display("FAIL load_return: busy2=%b rd2=%h pend_cnt=%0d, required 0/1234/1", busy2, rd2, pend_cnt);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (pend_cnt !== '0 || pend_any !== 1'b0 || busy2 !== 1'b0 || rd2 !== 32'h1234) begin
         miscompares++;
         $display("FAIL load_done: pend_cnt=%0d pend_any=%b busy2=%b rd2=%h, required 0/0/0/1234", pend_cnt, pend_any, busy2, rd2);
      end
   endtask

   task automatic test_set_clear();
      iss_en = 1'b1; iss_addr = 4'd4;
      web = 1'b1; wab = 4'd4; wdb = 32'hABCD;
      tick();
      idle();
      ra3 = 4'd4;
      #1;
      vectors++;
      if (busy3 !== 1'b1 || rd3 !== 32'hABCD || pend_cnt !== 5'd1) begin
         miscompares++;
         $display("FAIL set_beats_clear: busy3=%b rd3=%h pend_cnt=%0d, required 1/abcd/1", busy3, rd3, pend_cnt);
      end
      iss_en = 1'b1; iss_addr = 4'd15;
      wea = 1'b1; waa = 4'd4; wda = 32'h99;
      tick();
      idle();
      #1;
      vectors++;
      if (pend_cnt !== 5'd1 || busy3 !== 1'b1 || rd3 !== 32'h99) begin
         miscompares++;
         $display("FAIL pc_issue_porta: pend_cnt=%0d busy3=%b rd3=%h, required 1/1/99", pend_cnt, busy3, rd3);
      end
      web = 1'b1; wab = 4'd4; wdb = 32'h4444;
      tick();
      idle();
      #1;
      vectors++;
      if (pend_cnt !== '0 || busy3 !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_r4: pend_cnt=%0d busy3=%b, required 0/0", pend_cnt, busy3);
      end
   endtask

   task automatic test_reset_midload();
      wea = 1'b1; waa = 4'd1; wda = 32'hCAFE_0001;
      iss_en = 1'b1; iss_addr = 4'd1;
      tick();
      idle();
      iss_en = 1'b1; iss_addr = 4'd2;
      tick();
      iss_addr = 4'd9;
      tick();
      idle();
      ra1 = 4'd1; ra2 = 4'd2; ra3 = 4'd9;
      #1;
      vectors++;
      if (pend_cnt !== 5'd3 || rd1 !== 32'hCAFE_0001 || busy1 !== 1'b1) begin
         miscompares++;
         $display("FAIL three_loads: pend_cnt=%0d rd1=%h busy1=%b, required 3/cafe0001/1", pend_cnt, rd1, busy1);
      end
      #1;
      reset = 1'b1;
      #1;
      vectors++;
      if (pend_cnt !== '0 || pend_any !== 1'b0 || {busy1, busy2, busy3} !== 3'b000 || rd1 !== '0) begin
         miscompares++;
         $display("FAIL async_reset: pend_cnt=%0d pend_any=%b busy=%b%b%b rd1=%h, required 0/0/000/0", pend_cnt, pend_any, busy1, busy2, busy3, rd1);
      end
      for (int i = 0; i < NREG - 1; i++) mregs[i] = '0;
      mpend = '0;
      @(posedge clk); #2;
      reset = 1'b0;
      web = 1'b1; wab = 4'd2; wdb = 32'h77;
      #1;
      vectors++;
      if (busy2 !== 1'b0 || rd2 !== 32'h77) begin
         miscompares++;
         $display("FAIL late_load_bypass: busy2=%b rd2=%h, required 0/77", busy2, rd2);
      end
      tick();
      idle();
      #1;
      vectors++;
      if (rd2 !== 32'h77 || pend_cnt !== '0 || busy2 !== 1'b0) begin
         miscompares++;
         $display("FAIL late_load_store: rd2=%h pend_cnt=%0d busy2=%b, required 77/0/0", rd2, pend_cnt, busy2);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 400; n++) begin
         wea      = ($urandom_range(0, 2) != 0);
         web      = ($urandom_range(0, 2) == 0);
         iss_en   = ($urandom_range(0, 3) == 0);
         waa      = AW'($urandom_range(0, NREG - 1));
         wab      = ($urandom_range(0, 3) == 0) ? waa : AW'($urandom_range(0, NREG - 1));
         iss_addr = AW'($urandom_range(0, NREG - 1));
         wda      = $urandom;
         wdb      = $urandom;
         pc       = $urandom;
         ra1      = AW'($urandom_range(0, NREG - 1));
         ra2      = ($urandom_range(0, 2) == 0) ? wab : AW'($urandom_range(0, NREG - 1));
         ra3      = ($urandom_range(0, 2) == 0) ? waa : AW'($urandom_range(0, NREG - 1));
         #1;
         vectors++;
         if (rd1 !== exp_rd(ra1) || rd2 !== exp_rd(ra2) || rd3 !== exp_rd(ra3)) begin
            miscompares++;
            $display("FAIL rand_read #%0d: rd=%h/%h/%h, required %h/%h/%h", n, rd1, rd2, rd3, exp_rd(ra1), exp_rd(ra2), exp_rd(ra3));
         end
         vectors++;
         if (busy1 !== exp_busy(ra1) || busy2 !== exp_busy(ra2) || busy3 !== exp_busy(ra3)) begin
            miscompares++;
            $display("FAIL rand_busy #%0d: busy=%b%b%b, required %b%b%b", n, busy1, busy2, busy3, exp_busy(ra1), exp_busy(ra2), exp_busy(ra3));
         end
         vectors++;
         if (pend_cnt !== (AW+1)'($countones(mpend)) || pend_any !== (mpend != '0)) begin
            miscompares++;
            $display("FAIL rand_count #%0d: pend_cnt=%0d pend_any=%b, required %0d/%b", n, pend_cnt, pend_any, $countones(mpend), (mpend != '0));
         end
         tick();
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_dual_write();
      test_scoreboard();
      test_set_clear();
      test_reset_midload();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
